// File: rtl/control_sequencer.sv
// Microcoded control sequencer: steps one opcode through T0..T2 and
// drives registered datapath enables and immediates for each step.
module control_sequencer (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [31:0] imm,
    output logic        RAout,
    output logic        RBout,
    output logic        RZout,
    output logic        RAin,
    output logic        RBin,
    output logic        RZin,
    output logic [31:0] AddImmediate,
    output logic [31:0] RegisterAImmediate,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        FIN  = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [2:0] OP_LDA   = 3'd0;
    localparam logic [2:0] OP_ADDI  = 3'd1;
    localparam logic [2:0] OP_MOVAB = 3'd2;
    localparam logic [2:0] OP_MOVBA = 3'd3;
    localparam logic [2:0] OP_LDADD = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] imm_q, imm_d;

    logic        ra_out_d, rb_out_d, rz_out_d;
    logic        ra_in_d, rb_in_d, rz_in_d;
    logic [31:0] add_imm_d, ra_imm_d;
    logic        busy_d, done_d, illegal_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        imm_d   = imm_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    imm_d   = imm;
                    state_d = (opcode <= OP_LDADD) ? T0 : ERR;
                end
            end
            T0: begin
                if (op_q == OP_ADDI || op_q == OP_LDADD)
                    state_d = T1;
                else
                    state_d = FIN;
            end
            T1:      state_d = (op_q == OP_LDADD) ? T2 : FIN;
            T2:      state_d = FIN;
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode from the next state so values line up with the Tk cycle.
    always_comb begin
        ra_out_d  = 1'b0;
        rb_out_d  = 1'b0;
        rz_out_d  = 1'b0;
        ra_in_d   = 1'b0;
        rb_in_d   = 1'b0;
        rz_in_d   = 1'b0;
        add_imm_d = '0;
        ra_imm_d  = '0;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == FIN);
        illegal_d = (state_d == ERR);
        case (state_d)
            T0: begin
                case (op_d)
                    OP_LDA, OP_LDADD: begin
                        ra_imm_d = imm_d;
                        ra_in_d  = 1'b1;
                    end
                    OP_ADDI: begin
                        ra_out_d  = 1'b1;
                        add_imm_d = imm_d;
                        rz_in_d   = 1'b1;
                    end
                    OP_MOVAB: begin
                        ra_out_d = 1'b1;
                        rb_in_d  = 1'b1;
                    end
                    OP_MOVBA: begin
                        rb_out_d = 1'b1;
                        ra_in_d  = 1'b1;
                    end
                    default: ;
                endcase
            end
            T1: begin
                if (op_d == OP_ADDI) begin
                    rz_out_d = 1'b1;
                    rb_in_d  = 1'b1;
                end else if (op_d == OP_LDADD) begin
                    ra_out_d  = 1'b1;
                    add_imm_d = imm_d;
                    rz_in_d   = 1'b1;
                end
            end
            T2: begin
                rz_out_d = 1'b1;
                rb_in_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q            <= IDLE;
            op_q               <= '0;
            imm_q              <= '0;
            RAout              <= 1'b0;
            RBout              <= 1'b0;
            RZout              <= 1'b0;
            RAin               <= 1'b0;
            RBin               <= 1'b0;
            RZin               <= 1'b0;
            AddImmediate       <= '0;
            RegisterAImmediate <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            illegal            <= 1'b0;
        end else begin
            state_q            <= state_d;
            op_q               <= op_d;
            imm_q              <= imm_d;
            RAout              <= ra_out_d;
            RBout              <= rb_out_d;
            RZout              <= rz_out_d;
            RAin               <= ra_in_d;
            RBin               <= rb_in_d;
            RZin               <= rz_in_d;
            AddImmediate       <= add_imm_d;
            RegisterAImmediate <= ra_imm_d;
            busy               <= busy_d;
            done               <= done_d;
            illegal            <= illegal_d;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer with hand-written
// sequences for reset abort, start-while-busy and a random legal stream.
module tb_control_sequencer;

    typedef struct packed {
        logic [5:0]  ctl;
        logic        busy;
        logic        done;
        logic        ill;
        logic [31:0] add;
        logic [31:0] rai;
    } out_t;

    typedef struct {
        logic        start;
        logic [2:0]  op;
        logic [31:0] imm;
        out_t        exp;
    } vec_t;

    // ctl bit order: {RAout, RBout, RZout, RAin, RBin, RZin}
    localparam logic [5:0] C_RAO = 6'b100000;
    localparam logic [5:0] C_RBO = 6'b010000;
    localparam logic [5:0] C_RZO = 6'b001000;
    localparam logic [5:0] C_RAI = 6'b000100;
    localparam logic [5:0] C_RBI = 6'b000010;
    localparam logic [5:0] C_RZI = 6'b000001;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'd0;
    logic [31:0] imm = 32'd0;
    logic        RAout, RBout, RZout, RAin, RBin, RZin;
    logic [31:0] AddImmediate, RegisterAImmediate;
    logic        busy, done, illegal;

    int checks = 0;
    int errors = 0;

    out_t obs;
    assign obs = '{ctl: {RAout, RBout, RZout, RAin, RBin, RZin},
                   busy: busy, done: done, ill: illegal,
                   add: AddImmediate, rai: RegisterAImmediate};

    control_sequencer dut (
        .clk(clk),
        .clear(clear),
        .start(start),
        .opcode(opcode),
        .imm(imm),
        .RAout(RAout),
        .RBout(RBout),
        .RZout(RZout),
        .RAin(RAin),
        .RBin(RBin),
        .RZin(RZin),
        .AddImmediate(AddImmediate),
        .RegisterAImmediate(RegisterAImmediate),
        .busy(busy),
        .done(done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic out_t o(input logic [5:0] c, input logic b,
                               input logic d, input logic i,
                               input logic [31:0] a, input logic [31:0] r);
        out_t x;
        x.ctl = c; x.busy = b; x.done = d; x.ill = i;
        x.add = a; x.rai = r;
        return x;
    endfunction

    function automatic vec_t v(input logic s, input logic [2:0] op,
                               input logic [31:0] im, input out_t e);
        vec_t x;
        x.start = s; x.op = op; x.imm = im; x.exp = e;
        return x;
    endfunction

    // Reference: expected outputs in step k of opcode op (k == N is FIN).
    function automatic int nsteps(input logic [2:0] op);
        case (op)
            3'd1:    return 2;
            3'd4:    return 3;
            default: return 1;
        endcase
    endfunction

    function automatic out_t model(input logic [2:0] op, input int k,
                                   input logic [31:0] im);
        out_t x = o(6'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        if (k == nsteps(op)) x.done = 1'b1;
        else case ({op, k[1:0]})
            {3'd0, 2'd0}: begin x.ctl = C_RAI; x.rai = im; end
            {3'd1, 2'd0}: begin x.ctl = C_RAO | C_RZI; x.add = im; end
            {3'd1, 2'd1}: x.ctl = C_RZO | C_RBI;
            {3'd2, 2'd0}: x.ctl = C_RAO | C_RBI;
            {3'd3, 2'd0}: x.ctl = C_RBO | C_RAI;
            {3'd4, 2'd0}: begin x.ctl = C_RAI; x.rai = im; end
            {3'd4, 2'd1}: begin x.ctl = C_RAO | C_RZI; x.add = im; end
            {3'd4, 2'd2}: x.ctl = C_RZO | C_RBI;
            default: x = o(6'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        endcase
        return x;
    endfunction

    task automatic check(input string name, input out_t e);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s: got ctl=%b busy=%b done=%b ill=%b add=%h rai=%h, want ctl=%b busy=%b done=%b ill=%b add=%h rai=%h",
                     name, obs.ctl, obs.busy, obs.done, obs.ill, obs.add, obs.rai,
                     e.ctl, e.busy, e.done, e.ill, e.add, e.rai);
        end
    endtask

    task automatic step(input logic s, input logic [2:0] op,
                        input logic [31:0] im);
        start = s; opcode = op; imm = im;
        @(posedge clk);
        #1;
    endtask

    out_t z;
    vec_t vecs[24];

    initial begin
        z = o(6'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

        vecs[0]  = v(1, 3'd4, 32'h5,        o(C_RAI, 1, 0, 0, 32'h0, 32'h5));
        vecs[1]  = v(0, 3'd0, 32'h0,        o(C_RAO | C_RZI, 1, 0, 0, 32'h5, 32'h0));
        vecs[2]  = v(0, 3'd0, 32'h0,        o(C_RZO | C_RBI, 1, 0, 0, 32'h0, 32'h0));
        vecs[3]  = v(0, 3'd0, 32'h0,        o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        vecs[4]  = v(0, 3'd0, 32'h0,        z);
        vecs[5]  = v(1, 3'd1, 32'hFFFFFFFF, o(C_RAO | C_RZI, 1, 0, 0, 32'hFFFFFFFF, 32'h0));
        vecs[6]  = v(0, 3'd0, 32'h0,        o(C_RZO | C_RBI, 1, 0, 0, 32'h0, 32'h0));
        vecs[7]  = v(0, 3'd0, 32'h0,        o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        vecs[8]  = v(0, 3'd0, 32'h0,        z);
        vecs[9]  = v(1, 3'd6, 32'h1234,     o(6'b0, 1, 0, 1, 32'h0, 32'h0));
        vecs[10] = v(0, 3'd0, 32'h0,        z);
        vecs[11] = v(1, 3'd0, 32'h80000000, o(C_RAI, 1, 0, 0, 32'h0, 32'h80000000));
        vecs[12] = v(0, 3'd0, 32'h0,        o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        vecs[13] = v(0, 3'd0, 32'h0,        z);
        vecs[14] = v(1, 3'd2, 32'hDEAD,     o(C_RAO | C_RBI, 1, 0, 0, 32'h0, 32'h0));
        vecs[15] = v(0, 3'd0, 32'h0,        o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        vecs[16] = v(1, 3'd3, 32'h0,        z);
        vecs[17] = v(1, 3'd3, 32'h0,        o(C_RBO | C_RAI, 1, 0, 0, 32'h0, 32'h0));
        vecs[18] = v(1, 3'd5, 32'h9,        o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        vecs[19] = v(0, 3'd0, 32'h0,        z);
        vecs[20] = v(1, 3'd7, 32'h1,        o(6'b0, 1, 0, 1, 32'h0, 32'h0));
        vecs[21] = v(1, 3'd5, 32'h1,        z);
        vecs[22] = v(1, 3'd5, 32'h1,        o(6'b0, 1, 0, 1, 32'h0, 32'h0));
        vecs[23] = v(0, 3'd0, 32'h0,        z);

        #2 clear = 1'b0;
        #1 check("reset_state", z);
        @(negedge clk);
        clear = 1'b1;

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].start, vecs[i].op, vecs[i].imm);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Start pulsed during LDADD T1, then held through FIN.
        step(1, 3'd4, 32'h5);
        check("busy_ldadd_t0", o(C_RAI, 1, 0, 0, 32'h0, 32'h5));
        step(0, 3'd0, 32'h0);
        check("busy_ldadd_t1", o(C_RAO | C_RZI, 1, 0, 0, 32'h5, 32'h0));
        step(1, 3'd3, 32'h77);
        check("busy_ldadd_t2", o(C_RZO | C_RBI, 1, 0, 0, 32'h0, 32'h0));
        step(1, 3'd3, 32'h77);
        check("busy_ldadd_fin", o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        step(1, 3'd3, 32'h77);
        check("busy_idle_gap", z);
        step(1, 3'd3, 32'h77);
        check("busy_movba_t0", o(C_RBO | C_RAI, 1, 0, 0, 32'h0, 32'h0));
        step(0, 3'd0, 32'h0);
        check("busy_movba_fin", o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        step(0, 3'd0, 32'h0);
        check("busy_end_idle", z);

        // Reset during ADDI T1.
        step(1, 3'd1, 32'hABCD);
        check("rst_addi_t0", o(C_RAO | C_RZI, 1, 0, 0, 32'hABCD, 32'h0));
        step(0, 3'd0, 32'h0);
        check("rst_addi_t1", o(C_RZO | C_RBI, 1, 0, 0, 32'h0, 32'h0));
        #2 clear = 1'b0;
        #1 check("rst_async", z);
        @(posedge clk);
        #1 check("rst_held_no_done", z);
        clear = 1'b1;
        step(1, 3'd2, 32'h0);
        check("rst_movab_t0", o(C_RAO | C_RBI, 1, 0, 0, 32'h0, 32'h0));
        step(0, 3'd0, 32'h0);
        check("rst_movab_fin", o(6'b0, 1, 1, 0, 32'h0, 32'h0));
        step(0, 3'd0, 32'h0);
        check("rst_movab_idle", z);

        // Random stream of legal opcodes with noise on ignored inputs.
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  op;
            logic [31:0] im;
            op = 3'($urandom_range(0, 4));
            im = $urandom;
            step(1, op, im);
            for (int k = 0; k <= nsteps(op); k++) begin
                if (k > 0)
                    step(1'($urandom_range(0, 1)), 3'($urandom), $urandom);
                checks++;
                if ($countones({RAout, RBout, RZout}) > 1) begin
                    errors++;
                    $display("FAIL rnd_excl: got drives=%b, want at most one",
                             {RAout, RBout, RZout});
                end
                check($sformatf("rnd%0d_op%0d_k%0d", n, op, k), model(op, k, im));
            end
            step(0, 3'd0, 32'h0);
            check($sformatf("rnd%0d_idle", n), z);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
